axi_sram_wr_slave: RTL and testbench

AXI write-channel responder that terminates the AW/W/B handshakes driven by the interconnect's slave-side ports and converts each burst into single-word SRAM write cycles. Sits between one interconnect slave port (S0..S5) and a word-addressed SRAM macro. It handles one transaction at a time and returns a B response per burst. Bursts with an unsupported size or burst type return SLVERR.

---
 rtl/axi_sram_wr_slave_if.sv | 41 ++++
 rtl/axi_sram_wr_slave.sv | 158 +++++++++++++++
 tb/tb_axi_sram_wr_slave.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_wr_slave_if.sv
// AXI write-channel bundle (AW/W/B) between an interconnect slave port and
// the SRAM write responder.
interface axi_sram_wr_slave_if #(
  parameter int unsigned IDS_BITS  = 8,
  parameter int unsigned ADDR_BITS = 32
);
  logic [IDS_BITS-1:0]  AWID;
  logic [ADDR_BITS-1:0] AWADDR;
  logic [3:0]           AWLEN;
  logic [2:0]           AWSIZE;
  logic [1:0]           AWBURST;
  logic                 AWVALID;
  logic                 AWREADY;
  logic [31:0]          WDATA;
  logic [3:0]           WSTRB;
  logic                 WLAST;
  logic                 WVALID;
  logic                 WREADY;
  logic [IDS_BITS-1:0]  BID;
  logic [1:0]           BRESP;
  logic                 BVALID;
  logic                 BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_sram_wr_slave.sv
// AXI write responder: accepts one AW/W burst at a time, issues one
// registered SRAM word write per in-range beat, returns one B per burst.
// Optional feature macro: SRAM_WR_WRAP_BURST_EN (WRAP burst support).
module axi_sram_wr_slave #(
  parameter int unsigned IDS_BITS  = 8,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned MEM_AW    = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_sram_wr_slave_if.slave   s_axi,
  output logic                 mem_en,
  output logic [3:0]           mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [31:0]          mem_wdata
);

  localparam int unsigned CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(16);
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t              r_state, w_state_nxt;
  logic                r_awready, r_wready, r_bvalid;
  logic [IDS_BITS-1:0] r_id, r_bid;
  logic [1:0]          r_bresp;
  logic [3:0]          r_len;
  logic [1:0]          r_burst;
  logic [MEM_AW-1:0]   r_addr, w_addr_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_inc;
  logic                r_err, w_err_cap, w_err_beat, w_wr_beat, w_wrap_err;
  logic                w_aw_hs, w_w_hs, w_b_hs;
  logic                r_mem_en;
  logic [3:0]          r_mem_we;
  logic [MEM_AW-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic [ADDR_BITS-1:0] w_unused_awaddr;

  // Only the word-address bits of AWADDR reach the SRAM
  assign w_unused_awaddr = s_axi.AWADDR;

  assign s_axi.AWREADY = r_awready;
  assign s_axi.WREADY  = r_wready;
  assign s_axi.BVALID  = r_bvalid;
  assign s_axi.BID     = r_bid;
  assign s_axi.BRESP   = r_bresp;
  assign mem_en        = r_mem_en;
  assign mem_we        = r_mem_we;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;

  assign w_aw_hs = s_axi.AWVALID & r_awready;
  assign w_w_hs  = s_axi.WVALID  & r_wready;
  assign w_b_hs  = r_bvalid      & s_axi.BREADY;

`ifdef SRAM_WR_WRAP_BURST_EN
  logic [MEM_AW-1:0] w_wrap_mask;
  assign w_wrap_mask = MEM_AW'(r_len);
  // WRAP is legal only for 2/4/8/16-beat bursts
  assign w_wrap_err = !((s_axi.AWLEN == 4'd1) || (s_axi.AWLEN == 4'd3) ||
                        (s_axi.AWLEN == 4'd7) || (s_axi.AWLEN == 4'd15));
`else
  assign w_wrap_err = 1'b1;
`endif

  // Burst legality decided once at AW capture
  assign w_err_cap = (s_axi.AWSIZE != 3'b010) || (s_axi.AWBURST == BURST_RSVD) ||
                     ((s_axi.AWBURST == BURST_WRAP) && w_wrap_err);

  // Beat bookkeeping: write gating, saturating count, late/early WLAST error
  assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_wr_beat  = !r_err && (r_cnt <= CNT_W'(r_len));
  assign w_err_beat = r_err || (r_cnt > CNT_W'(r_len)) ||
                      (s_axi.WLAST && (w_cnt_inc != CNT_W'(r_len) + CNT_W'(1)));

  // Next word address per burst type
  always_comb begin
    w_addr_nxt = r_addr + MEM_AW'(1);
    case (r_burst)
      BURST_FIXED: w_addr_nxt = r_addr;
`ifdef SRAM_WR_WRAP_BURST_EN
      BURST_WRAP:  w_addr_nxt = (r_addr & ~w_wrap_mask) |
                                ((r_addr + MEM_AW'(1)) & w_wrap_mask);
`endif
      default: ;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_aw_hs) w_state_nxt = DATA;
      DATA:    if (w_w_hs && s_axi.WLAST) w_state_nxt = RESP;
      RESP:    if (w_b_hs) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered handshakes, burst context, response and SRAM write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_awready   <= 1'b0;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_id        <= '0;
      r_bid       <= '0;
      r_bresp     <= 2'b00;
      r_len       <= 4'd0;
      r_burst     <= 2'b00;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 4'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_awready <= (w_state_nxt == IDLE);
      r_wready  <= (w_state_nxt == DATA);
      r_bvalid  <= (w_state_nxt == RESP);
      r_mem_en  <= 1'b0;
      if (w_aw_hs) begin
        r_id    <= s_axi.AWID;
        r_len   <= s_axi.AWLEN;
        r_burst <= s_axi.AWBURST;
        r_addr  <= s_axi.AWADDR[MEM_AW+1:2];
        r_cnt   <= '0;
        r_err   <= w_err_cap;
      end
      if (w_w_hs) begin
        if (w_wr_beat) begin
          r_mem_en    <= 1'b1;
          r_mem_we    <= s_axi.WSTRB;
          r_mem_addr  <= r_addr;
          r_mem_wdata <= s_axi.WDATA;
        end
        r_cnt  <= w_cnt_inc;
        r_addr <= w_addr_nxt;
        r_err  <= w_err_beat;
        if (s_axi.WLAST) begin
          r_bid   <= r_id;
          r_bresp <= w_err_beat ? 2'b10 : 2'b00;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_wr_slave.sv
// Scoreboard bench for axi_sram_wr_slave: expected SRAM writes and B responses
// are queued while stimulus is driven and checked as the DUT produces them.
module tb_axi_sram_wr_slave;

  localparam int unsigned MEM_AW = 14;
`ifdef SRAM_WR_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [MEM_AW-1:0] addr;
    logic [3:0]        we;
    logic [31:0]       data;
  } wr_t;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } b_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  int  n_total = 0;
  int  n_bad   = 0;
  wr_t wr_q[$];
  b_t  b_q[$];
  wr_t mon_e;

  axi_sram_wr_slave_if #(.IDS_BITS(8), .ADDR_BITS(32)) bus ();

  axi_sram_wr_slave #(.IDS_BITS(8), .ADDR_BITS(32), .MEM_AW(MEM_AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_axi     (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Independent address model: FIXED holds, INCR counts, WRAP rotates in an aligned block
  function automatic logic [MEM_AW-1:0] exp_addr(input logic [MEM_AW-1:0] start,
                                                 input logic [3:0] len,
                                                 input logic [1:0] burst, input int i);
    int n, s, base;
    n = int'(len) + 1;
    s = int'(start);
    case (burst)
      2'b00:   return start;
      2'b10: begin
        base = (s / n) * n;
        return MEM_AW'(base + ((s - base + i) % n));
      end
      default: return MEM_AW'(s + i);
    endcase
  endfunction

  // SRAM port monitor plus ready/valid exclusivity
  always @(negedge clk) begin
    if (rst) begin
      check_val("rdy_excl", 64'($countones({bus.AWREADY, bus.WREADY, bus.BVALID}) <= 1), 1);
      if (mem_en) begin
        if (wr_q.size() == 0) check_val("unexp_wr", mem_en, 0);
        else begin
          mon_e = wr_q.pop_front();
          check_val("mem_addr",  mem_addr,  mon_e.addr);
          check_val("mem_we",    mem_we,    mon_e.we);
          check_val("mem_wdata", mem_wdata, mon_e.data);
        end
      end
    end
  end

  task automatic send_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t = 0;
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    while (!bus.AWREADY && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.AWREADY) check_val("aw_timeout", bus.AWREADY, 1);
    @(posedge clk); #1;
    bus.AWVALID = 1'b0;
    check_val("wready_after_aw", bus.WREADY, 1);
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int t = 0;
    bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    while (!bus.WREADY && t < 50) begin @(posedge clk); #1; t++; end
    if (!bus.WREADY) check_val("w_timeout", bus.WREADY, 1);
    @(posedge clk); #1;
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
  endtask

  task automatic wait_b(input int hold);
    int t = 0;
    b_t be;
    while (!bus.BVALID && t < 50) begin @(posedge clk); #1; t++; end
    check_val("b_seen", bus.BVALID, 1);
    if (b_q.size() == 0) check_val("b_q_empty", b_q.size(), 1);
    else begin
      be = b_q.pop_front();
      check_val("bid",   bus.BID,   be.id);
      check_val("bresp", bus.BRESP, be.resp);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        check_val("bvalid_hold",  bus.BVALID,  1);
        check_val("bid_hold",     bus.BID,     be.id);
        check_val("bresp_hold",   bus.BRESP,   be.resp);
        check_val("awready_hold", bus.AWREADY, 0);
      end
    end
    bus.BREADY = 1'b1;
    @(posedge clk); #1;
    bus.BREADY = 1'b0;
    check_val("b_done_bvalid",  bus.BVALID,  0);
    check_val("b_done_awready", bus.AWREADY, 1);
  endtask

  task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [3:0] strb,
                          input int nbeats, input int hold, input logic [31:0] d0);
    logic [31:0] d [0:19];
    logic        err;
    logic        legal_wrap;
    legal_wrap = WRAP_EN && (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15);
    err = (size != 3'd2) || (burst == 2'd3) || (burst == 2'd2 && !legal_wrap);
    for (int i = 0; i < nbeats; i++) begin
      d[i] = (i == 0) ? d0 : $urandom;
      if (!err && i <= int'(len))
        wr_q.push_back('{addr: exp_addr(addr[MEM_AW+1:2], len, burst, i), we: strb, data: d[i]});
    end
    b_q.push_back('{id: id, resp: (err || nbeats != int'(len) + 1) ? 2'b10 : 2'b00});
    send_aw(id, addr, len, size, burst);
    for (int i = 0; i < nbeats; i++) send_w(d[i], strb, i == nbeats - 1);
    check_val("bvalid_lat", bus.BVALID, 1);
    wait_b(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_awready", bus.AWREADY, 0);
    check_val("rst_wready",  bus.WREADY,  0);
    check_val("rst_bvalid",  bus.BVALID,  0);
    check_val("rst_bid",     bus.BID,     0);
    check_val("rst_bresp",   bus.BRESP,   0);
    check_val("rst_mem_en",  mem_en,      0);
    check_val("rst_mem_we",  mem_we,      0);
    check_val("rst_mem_addr", mem_addr,   0);
    check_val("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("awready_after_rst", bus.AWREADY, 1);

    // Single beat, 4-beat INCR with stalled B, FIXED, bad size
    do_burst(8'h5A, 32'h0000_0010, 4'd0, 3'd2, 2'b01, 4'hF, 1, 0, 32'hDEAD_BEEF);
    do_burst(8'h21, 32'h0000_0100, 4'd3, 3'd2, 2'b01, 4'h3, 4, 5, 32'h1111_0000);
    do_burst(8'h33, 32'h0000_0100, 4'd2, 3'd2, 2'b00, 4'hF, 3, 0, 32'h2222_0000);
    do_burst(8'h44, 32'h0000_0100, 4'd2, 3'd1, 2'b01, 4'hF, 3, 1, 32'h3333_0000);
    // Early and late WLAST
    do_burst(8'h55, 32'h0000_0200, 4'd3, 3'd2, 2'b01, 4'hF, 2, 0, 32'h4444_0000);
    do_burst(8'h66, 32'h0000_0300, 4'd1, 3'd2, 2'b01, 4'hC, 4, 0, 32'h5555_0000);
    // WRAP (outcome depends on build), reserved burst, zero strobe, address rollover
    do_burst(8'h77, 32'h0000_0018, 4'd3, 3'd2, 2'b10, 4'hF, 4, 0, 32'h6666_0000);
    do_burst(8'h88, 32'h0000_0040, 4'd1, 3'd2, 2'b11, 4'hF, 2, 0, 32'h7777_0000);
    do_burst(8'h99, 32'h0000_0020, 4'd0, 3'd2, 2'b01, 4'h0, 1, 0, 32'h8888_0000);
    do_burst(8'hAA, 32'h0000_FFF8, 4'd3, 3'd2, 2'b01, 4'h5, 4, 0, 32'h9999_0000);
    for (int r = 0; r < 4; r++) begin
      logic [3:0] rl;
      rl = 4'($urandom_range(0, 7));
      do_burst(8'($urandom), $urandom & 32'hFFFF_FFFC, rl, 3'd2, 2'b01, 4'($urandom),
               int'(rl) + 1, int'($urandom_range(0, 2)), $urandom);
    end

    // Reset mid-burst: beat 2's write pulse is killed before it is sampled
    wr_q.push_back('{addr: MEM_AW'(14'h0100), we: 4'hF, data: 32'hAAAA_0001});
    send_aw(8'hBB, 32'h0000_0400, 4'd3, 3'd2, 2'b01);
    send_w(32'hAAAA_0001, 4'hF, 1'b0);
    send_w(32'hAAAA_0002, 4'hF, 1'b0);
    rst = 1'b0;
    #1;
    check_val("rst_mid_mem_en", mem_en,     0);
    check_val("rst_mid_wready", bus.WREADY, 0);
    check_val("rst_mid_bvalid", bus.BVALID, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_hold_bvalid", bus.BVALID, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("rst_rel_bvalid",  bus.BVALID,  0);
    check_val("rst_rel_awready", bus.AWREADY, 1);
    do_burst(8'hCC, 32'h0000_0044, 4'd0, 3'd2, 2'b01, 4'hF, 1, 0, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    check_val("wr_q_drained", wr_q.size(), 0);
    check_val("b_q_drained",  b_q.size(),  0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
